// File: rtl/median_filter_pkg.sv
// Shared constants and FSM encoding for the 5x5 median filter pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package median_filter_pkg;

  localparam int PIXEL_W  = 8;
  localparam int WIN_SIZE = 5;
  localparam int NUM_LB   = WIN_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/median_filter_5x5_window_line_buffer.sv
// One raster line of pixel storage, single port, read-before-write at addr.
// Latency: rd_dat is combinational from addr; write lands on the enabled edge.
// Backpressure: none; en gates the write, the read is always live.
// Ports: clk, en (write enable), addr (column), wr_dat (pixel in), rd_dat (old pixel at addr).
module line_buffer #(
  parameter int DEPTH   = 640,
  parameter int PIXEL_W = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIXEL_W-1:0]       wr_dat,
  output logic [PIXEL_W-1:0]       rd_dat
);

  // Contents are intentionally never reset; the window's counters decide validity.
  logic [PIXEL_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= wr_dat;
    end
  end

  // Read returns the value from before this cycle's write, so chained buffers shift down a row.
  assign rd_dat = mem_q[addr];

endmodule

// File: rtl/median_filter_5x5_window.sv
// Turns a raster pixel stream into 5x5 interior neighbourhoods S1..S25 for the calc stage.
// Latency: window and done_o registered, valid 1 cycle after the accepting edge of pixel (r,c).
// Backpressure: none; every done_i=1 cycle accepts a pixel, done_i=0 freezes everything.
// Ports: clk, rst_n (sync, active low), done_i/data_i (pixel in), S1..S25 (row-major window,
//        S25 newest), done_o (valid interior window), frame_done_o (last window of frame).
module median_filter_5x5_window
  import median_filter_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               done_i,
  input  logic [PIXEL_W-1:0] data_i,
  output logic [PIXEL_W-1:0] S1,  output logic [PIXEL_W-1:0] S2,  output logic [PIXEL_W-1:0] S3,
  output logic [PIXEL_W-1:0] S4,  output logic [PIXEL_W-1:0] S5,  output logic [PIXEL_W-1:0] S6,
  output logic [PIXEL_W-1:0] S7,  output logic [PIXEL_W-1:0] S8,  output logic [PIXEL_W-1:0] S9,
  output logic [PIXEL_W-1:0] S10, output logic [PIXEL_W-1:0] S11, output logic [PIXEL_W-1:0] S12,
  output logic [PIXEL_W-1:0] S13, output logic [PIXEL_W-1:0] S14, output logic [PIXEL_W-1:0] S15,
  output logic [PIXEL_W-1:0] S16, output logic [PIXEL_W-1:0] S17, output logic [PIXEL_W-1:0] S18,
  output logic [PIXEL_W-1:0] S19, output logic [PIXEL_W-1:0] S20, output logic [PIXEL_W-1:0] S21,
  output logic [PIXEL_W-1:0] S22, output logic [PIXEL_W-1:0] S23, output logic [PIXEL_W-1:0] S24,
  output logic [PIXEL_W-1:0] S25,
  output logic               done_o,
  output logic               frame_done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN   = CW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(WIN_SIZE - 2);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               frame_done_q, frame_done_d;
  logic [PIXEL_W-1:0] win_q [WIN_SIZE][WIN_SIZE];
  logic [PIXEL_W-1:0] win_d [WIN_SIZE][WIN_SIZE];

  logic [PIXEL_W-1:0] lb_wr [NUM_LB];
  logic [PIXEL_W-1:0] lb_rd [NUM_LB];
  logic               lb_en;
  logic               last_col, last_row;

  // Hold line buffers during reset so a reset cycle never looks like a pixel.
  assign lb_en = done_i & rst_n;

  // lb0 takes the new pixel; each deeper buffer takes the row its predecessor is displacing.
  always_comb begin
    lb_wr[0] = data_i;
    for (int g = 1; g < NUM_LB; g++) begin
      lb_wr[g] = lb_rd[g-1];
    end
  end

  for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
    line_buffer #(.DEPTH(IMG_W), .PIXEL_W(PIXEL_W)) u_lb (
      .clk    (clk),
      .en     (lb_en),
      .addr   (col_q),
      .wr_dat (lb_wr[g]),
      .rd_dat (lb_rd[g])
    );
  end

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    win_d        = win_q;
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;

    if (done_i) begin
      // Shift left; new right column is lb3 (oldest row) down to the live pixel.
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int k = 0; k < WIN_SIZE - 1; k++) begin
          win_d[r][k] = win_q[r][k+1];
        end
      end
      for (int r = 0; r < NUM_LB; r++) begin
        win_d[r][WIN_SIZE-1] = lb_rd[NUM_LB-1-r];
      end
      win_d[WIN_SIZE-1][WIN_SIZE-1] = data_i;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      // Column mask also suppresses the stale cross-line windows right after a row wrap.
      done_d       = (state_q == ST_RUN) && (col_q >= COL_WIN) && (row_q >= ROW_WIN);
      frame_done_d = (state_q == ST_RUN) && last_col && last_row;

      unique case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (last_col && row_q == ROW_FILLD) state_d = ST_RUN;
        ST_RUN:  if (last_col && last_row) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int k = 0; k < WIN_SIZE; k++) begin
          win_q[r][k] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign done_o       = done_q;
  assign frame_done_o = frame_done_q;

  assign S1  = win_q[0][0]; assign S2  = win_q[0][1]; assign S3  = win_q[0][2];
  assign S4  = win_q[0][3]; assign S5  = win_q[0][4]; assign S6  = win_q[1][0];
  assign S7  = win_q[1][1]; assign S8  = win_q[1][2]; assign S9  = win_q[1][3];
  assign S10 = win_q[1][4]; assign S11 = win_q[2][0]; assign S12 = win_q[2][1];
  assign S13 = win_q[2][2]; assign S14 = win_q[2][3]; assign S15 = win_q[2][4];
  assign S16 = win_q[3][0]; assign S17 = win_q[3][1]; assign S18 = win_q[3][2];
  assign S19 = win_q[3][3]; assign S20 = win_q[3][4]; assign S21 = win_q[4][0];
  assign S22 = win_q[4][1]; assign S23 = win_q[4][2]; assign S24 = win_q[4][3];
  assign S25 = win_q[4][4];

endmodule

// File: tb/tb_median_filter_5x5_window.sv
// Directed bench for median_filter_5x5_window on an 8x8 ramp image (pixel = r*8+c).
// Latency: outputs sampled 1 ns after the accepting edge.
// Backpressure: exercised through idle (done_i=0) gaps.
module tb_median_filter_5x5_window;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13;
  logic [7:0] S14, S15, S16, S17, S18, S19, S20, S21, S22, S23, S24, S25;
  logic       done_o;
  logic       frame_done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median_filter_5x5_window #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .done_i(done_i), .data_i(data_i),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7), .S8(S8), .S9(S9),
    .S10(S10), .S11(S11), .S12(S12), .S13(S13), .S14(S14), .S15(S15), .S16(S16),
    .S17(S17), .S18(S18), .S19(S19), .S20(S20), .S21(S21), .S22(S22), .S23(S23),
    .S24(S24), .S25(S25),
    .done_o(done_o), .frame_done_o(frame_done_o)
  );

  logic [199:0] dut_win;
  assign dut_win = {S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13,
                    S14, S15, S16, S17, S18, S19, S20, S21, S22, S23, S24, S25};

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Ramp image: window element (i,j) of the window ending at (r,c) is pixel (r-4+i, c-4+j).
  function automatic logic [199:0] exp_win(input int r, input int c);
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        v[(24 - (i*5 + j))*8 +: 8] = 8'((r - 4 + i)*W + (c - 4 + j));
      end
    end
    return v;
  endfunction

  task automatic push(input int r, input int c, inout int pulses);
    logic exp_v;
    @(negedge clk);
    done_i = 1'b1;
    data_i = 8'(r*W + c);
    @(posedge clk);
    #1;
    exp_v = (r >= 4) && (c >= 4);
    chk($sformatf("done_o(%0d,%0d)", r, c), 200'(done_o), 200'(exp_v));
    chk($sformatf("frame_done_o(%0d,%0d)", r, c), 200'(frame_done_o),
        200'((r == H-1) && (c == W-1)));
    if (exp_v) begin
      pulses++;
      chk($sformatf("window(%0d,%0d)", r, c), dut_win, exp_win(r, c));
    end
    if (r == 4 && c == 4) begin
      chk("first_S1",  200'(S1),  200'(0));
      chk("first_S5",  200'(S5),  200'(4));
      chk("first_S13", 200'(S13), 200'(18));
      chk("first_S21", 200'(S21), 200'(32));
      chk("first_S25", 200'(S25), 200'(36));
    end
    if (r == 5 && c == 4) begin
      chk("wrap_S1",  200'(S1),  200'(8));
      chk("wrap_S5",  200'(S5),  200'(12));
      chk("wrap_S21", 200'(S21), 200'(40));
      chk("wrap_S25", 200'(S25), 200'(44));
    end
    if (r == H-1 && c == W-1) begin
      chk("last_S25", 200'(S25), 200'(63));
      chk("last_S1",  200'(S1),  200'(27));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    done_i = 1'b0;
    data_i = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    chk("idle_done_o", 200'(done_o), 200'(0));
    chk("idle_frame_done_o", 200'(frame_done_o), 200'(0));
  endtask

  task automatic run_frame(input int idle_pct, input string name);
    int pulses;
    int gaps;
    pulses = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        gaps = 0;
        while (gaps < 4 && $urandom_range(0, 99) < idle_pct) begin
          idle();
          gaps++;
        end
        push(r, c, pulses);
      end
    end
    chk({name, "_pulses"}, 200'(pulses), 200'(16));
  endtask

  initial begin
    int scratch;
    scratch = 0;

    // Reset held 3 clocks while pixels are being offered.
    rst_n  = 1'b0;
    done_i = 1'b1;
    data_i = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_window", dut_win, 200'(0));
    chk("reset_done_o", 200'(done_o), 200'(0));
    chk("reset_frame_done_o", 200'(frame_done_o), 200'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    done_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_done_o", 200'(done_o), 200'(0));

    // Continuous frame, then a back-to-back frame, then a frame with random idles.
    run_frame(0, "frame_a");
    run_frame(0, "frame_b");
    run_frame(50, "frame_gappy");

    // Partial frame up to (5,2), one reset clock, then a full restart.
    for (int r = 0; r <= 5; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 5 || c <= 2) push(r, c, scratch);
      end
    end
    @(negedge clk);
    rst_n  = 1'b0;
    done_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_done_o", 200'(done_o), 200'(0));
    chk("midreset_window", dut_win, 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, "frame_restart");

    @(negedge clk);
    done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tail_done_o", 200'(done_o), 200'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
